// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI peripheral constants and a constant-foldable clog2.
package spi_pkg;
    localparam int SPI_DATA_W = 25;
    localparam int SPI_DEPTH  = 24;

    // Returns at least 1 so a pointer always has one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/spi_fifo_ptr.sv
// spi_fifo_ptr: modulo-DEPTH pointer with a wrap flag that toggles on each wrap.
module spi_fifo_ptr
    import spi_pkg::*;
#(
    parameter int DEPTH = SPI_DEPTH,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             flush,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr,
    output logic             wrap
);
    logic last;
    assign last = ptr == PTR_W'(DEPTH - 1);

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            ptr  <= '0;
            wrap <= 1'b0;
        end else if (flush) begin
            ptr  <= '0;
            wrap <= 1'b0;
        end else if (inc) begin
            ptr  <= last ? '0 : ptr + 1'b1;
            wrap <= wrap ^ last;
        end
    end
endmodule

// File: rtl/spi_fifo_param.sv
// spi_fifo_param: parametrised FWFT FIFO with count, almost flags and sticky errors.
module spi_fifo_param
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int DEPTH    = SPI_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = clog2(DEPTH + 1),
    localparam int PTR_W   = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              flush,
    input  logic              wrreq,
    input  logic [DATA_W-1:0] data,
    input  logic              rdreq,
    output logic [DATA_W-1:0] q,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic              wwrap, rwrap;
    logic              wr_ok, rd_ok, ov_ev, un_ev;
    logic [CNT_W-1:0]  count_nxt;

    spi_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clock(clock), .sclr(sclr), .flush(flush), .inc(wr_ok), .ptr(wptr), .wrap(wwrap)
    );
    spi_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clock(clock), .sclr(sclr), .flush(flush), .inc(rd_ok), .ptr(rptr), .wrap(rwrap)
    );

    // Full/empty decode straight from the pointer registers, so they track the last edge.
    assign empty = (wptr == rptr) && (wwrap == rwrap);
    assign full  = (wptr == rptr) && (wwrap != rwrap);

    assign wr_ok = wrreq && (!full || rdreq) && !flush;
    assign rd_ok = rdreq && !empty && !flush;
    assign ov_ev = wrreq && full && !rdreq && !flush;
    assign un_ev = rdreq && empty && !flush;

    always_comb begin
        count_nxt = flush ? '0 : count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            almost_full  <= count_nxt >= CNT_W'(AF_LEVEL);
            almost_empty <= count_nxt <= CNT_W'(AE_LEVEL);
            overflow     <= ov_ev || (overflow && !clr_err);
            underflow    <= un_ev || (underflow && !clr_err);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem[wptr] <= data;
    end

    assign q = mem[rptr];
endmodule

// File: tb/tb_spi_fifo_param.sv
// tb_spi_fifo_param: scoreboard bench driving a DEPTH=24 and a DEPTH=5 instance.
module tb_spi_fifo_param;
    logic        clk, rst;
    logic [1:0]  wrreq, rdreq, flush, clr_err;
    logic [1:0]  full, empty, af, ae, ov, un;
    logic [24:0] data [2];
    logic [24:0] q [2];
    logic [4:0]  cnt24;
    logic [2:0]  cnt5;

    logic [24:0] sb0 [$];
    logic [24:0] sb1 [$];
    int mc [2];
    bit mov [2];
    bit mun [2];
    int dep [2] = '{24, 5};
    int afl [2] = '{22, 4};
    int ael [2] = '{2, 1};
    int checks = 0;
    int errors = 0;

    spi_fifo_param dut24 (
        .clock(clk), .sclr(rst), .flush(flush[0]), .wrreq(wrreq[0]), .data(data[0]),
        .rdreq(rdreq[0]), .q(q[0]), .full(full[0]), .empty(empty[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt24),
        .overflow(ov[0]), .underflow(un[0]), .clr_err(clr_err[0])
    );

    spi_fifo_param #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
        .clock(clk), .sclr(rst), .flush(flush[1]), .wrreq(wrreq[1]), .data(data[1]),
        .rdreq(rdreq[1]), .q(q[1]), .full(full[1]), .empty(empty[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt5),
        .overflow(ov[1]), .underflow(un[1]), .clr_err(clr_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // A read is presented on q during the cycle rdreq is high; pop before the edge.
    always @(negedge clk) begin
        if (rdreq[0] && !flush[0] && sb0.size() > 0) chk("q24", q[0], sb0.pop_front());
        if (rdreq[1] && !flush[1] && sb1.size() > 0) chk("q5", q[1], sb1.pop_front());
    end

    task automatic check_status(input int k);
        int c;
        c = (k == 1) ? int'(cnt5) : int'(cnt24);
        chk($sformatf("count%0d", k), c, mc[k]);
        chk($sformatf("flags%0d", k), {full[k], empty[k], af[k], ae[k]},
            {mc[k] == dep[k], mc[k] == 0, mc[k] >= afl[k], mc[k] <= ael[k]});
        chk($sformatf("err%0d", k), {ov[k], un[k]}, {mov[k], mun[k]});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; mov[k] = 0; mun[k] = 0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic step(input int k, input bit w, input bit r, input logic [24:0] d,
                        input bit f = 0, input bit c = 0);
        bit wa, ra, fm, em;
        fm = mc[k] == dep[k];
        em = mc[k] == 0;
        wa = w && (!fm || r) && !f;
        ra = r && !em && !f;
        wrreq[k] = w; rdreq[k] = r; data[k] = d; flush[k] = f; clr_err[k] = c;
        @(posedge clk);
        #1;
        wrreq[k] = 0; rdreq[k] = 0; flush[k] = 0; clr_err[k] = 0;
        mov[k] = (w && fm && !r && !f) || (mov[k] && !c);
        mun[k] = (r && em && !f) || (mun[k] && !c);
        if (f) begin
            mc[k] = 0;
            if (k == 0) sb0.delete(); else sb1.delete();
        end else begin
            mc[k] += int'(wa) - int'(ra);
            if (wa) begin
                if (k == 0) sb0.push_back(d); else sb1.push_back(d);
            end
        end
        check_status(k);
    endtask

    initial begin
        wrreq = 0; rdreq = 0; flush = 0; clr_err = 0;
        data[0] = 0; data[1] = 0;
        model_reset();
        rst = 1'b1;
        #12;
        check_status(0);
        check_status(1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 24; i++) step(0, 1, 0, 25'(i));
        for (int i = 0; i < 24; i++) step(0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 5; i++) step(1, 1, 0, 25'(c * 16 + i + 1));
            for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        end
        for (int i = 0; i < 24; i++) step(0, 1, 0, 25'(100 + i));
        for (int i = 0; i < 10; i++) step(0, 1, 1, 25'(200 + i));
        step(0, 1, 0, 25'h0dead);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 24; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 25'h55);
        step(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 25'(300 + i));
        step(0, 1, 0, 25'h999, 1);
        step(0, 1, 0, 25'h77);
        step(0, 0, 1, 0);
        step(0, 1, 0, 25'h1);
        step(0, 1, 0, 25'h2);
        step(0, 1, 0, 25'h3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_status(0);
        check_status(1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(0, 1, 0, 25'habc);
        step(0, 0, 1, 0);
        step(1, 1, 0, 25'h1234);
        step(1, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
